// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle for spi_regfile_peripheral.
// master drives sclk/copi/ncs; slave drives cipo/cipo_oe.
interface spi_regfile_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (
    output sclk,
    output copi,
    output ncs,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  sclk,
    input  copi,
    input  ncs,
    output cipo,
    output cipo_oe
  );
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode 0 register file: write, read-back, wr strobe, frame error.
// Ports: clk, rst_n, spi (slave pins), reg_flat, wr_strobe, wr_addr, frame_err.
module spi_regfile_peripheral #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] reg_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam int REG_W = NUM_REGS * DATA_W;

  localparam logic [CNT_W-1:0] CNT_CMD =
    CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME =
    CNT_W'(FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_OVER
  } state_e;

  // bit0 = stage 1, bit1 = stage 2, bit2 = edge-detect stage
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ncs_sync_q, ncs_sync_d;
  logic [1:0] copi_sync_q, copi_sync_d;

  state_e             state_q, state_d;
  logic [FRAME-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rd_sh_q, rd_sh_d;
  logic               cipo_q, cipo_d;
  logic               cipo_oe_q, cipo_oe_d;
  logic [REG_W-1:0]   regs_q, regs_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               frame_err_q, frame_err_d;

  logic               sclk_rise, sclk_fall;
  logic               ncs_rise, ncs_fall;
  logic               ncs_s, copi_s;
  logic [FRAME-1:0]   sh_in;
  logic [ADDR_W-1:0]  rd_addr, cm_addr;
  logic [DATA_W-1:0]  rd_val;
  logic               cm_hit;
  logic               data_st;
  logic               full;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi.sclk};
    ncs_sync_d  = {ncs_sync_q[1:0], spi.ncs};
    copi_sync_d = {copi_sync_q[0], spi.copi};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ncs_rise  = ncs_sync_q[1] & ~ncs_sync_q[2];
  assign ncs_fall  = ~ncs_sync_q[1] & ncs_sync_q[2];
  assign ncs_s     = ncs_sync_q[1];
  assign copi_s    = copi_sync_q[1];

  assign sh_in   = {sh_q[FRAME-2:0], copi_s};
  // address as it stands once the last command bit is in
  assign rd_addr = sh_in[ADDR_W-1:0];
  assign cm_addr = sh_q[DATA_W +: ADDR_W];
  assign data_st = (state_q == S_WDATA) ||
                   (state_q == S_RDATA);
  assign full    = (cnt_q == CNT_FRAME);

  // address decode by match keeps out-of-range addresses harmless
  always_comb begin
    rd_val = '0;
    cm_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k))
        rd_val = regs_q[k*DATA_W +: DATA_W];
      if (cm_addr == ADDR_W'(k))
        cm_hit = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    rd_sh_d     = rd_sh_q;
    cipo_d      = cipo_q;
    cipo_oe_d   = ~ncs_sync_q[0];
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = frame_err_q;

    if (ncs_fall) begin
      state_d     = S_CMD;
      sh_d        = '0;
      cnt_d       = '0;
      rd_sh_d     = '0;
      frame_err_d = 1'b0;
    end else if (ncs_rise) begin
      if (state_q != S_IDLE) begin
        state_d     = S_IDLE;
        frame_err_d = !(data_st && full);
        if (state_q == S_WDATA && full &&
            sh_q[FRAME-1] && cm_hit) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (cm_addr == ADDR_W'(k))
              regs_d[k*DATA_W +: DATA_W] =
                sh_q[DATA_W-1:0];
          wr_addr_d   = cm_addr;
          wr_strobe_d = 1'b1;
        end
      end
    end else if (!ncs_s && sclk_rise) begin
      unique case (state_q)
        S_CMD: begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_CMD) begin
            if (sh_in[ADDR_W]) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_RDATA;
              rd_sh_d = rd_val;
            end
          end
        end
        S_WDATA, S_RDATA: begin
          if (full) begin
            state_d = S_OVER;
          end else begin
            sh_d  = sh_in;
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end else if (!ncs_s && sclk_fall &&
                 state_q == S_RDATA) begin
      // zeros shift in, so cipo idles low after DATA_W bits
      cipo_d  = rd_sh_q[DATA_W-1];
      rd_sh_d = rd_sh_q << 1;
    end

    if (state_d != S_RDATA)
      cipo_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '0;
      copi_sync_q <= '0;
      state_q     <= S_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      rd_sh_q     <= '0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      copi_sync_q <= copi_sync_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      rd_sh_q     <= rd_sh_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;
  assign reg_flat    = regs_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;

endmodule
